// File: rtl/vstreamout_collector_pkg.sv
// Shared definitions for the stream-out collector: column count, output
// buffer depth and the collector FSM state type.
package vstreamout_collector_pkg;

  // Number of CGRA columns feeding the collector
  localparam int num_col = 4;

  localparam int NUM_COL_DEFAULT    = num_col;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

endpackage

// File: rtl/vstreamout_collector_fifo.sv
// Output buffer for the collector: a power-of-two deep first-in first-out
// queue. The full flag comes from the registered occupancy, so a push into
// a full buffer only lands when a pop happens in the same cycle.
module vstreamout_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage array holds data only, so it carries no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy holds on simultaneous push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vstreamout_collector.sv
// Stream-out collector: picks one CGRA column per the one-hot mux_control,
// queues its beats in a small buffer and presents them as an AXI-Stream
// master. tlast is only raised for the last column's done beat.
module vstreamout_collector
  import vstreamout_collector_pkg::*;
#(
  parameter int NUM_COL    = NUM_COL_DEFAULT,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            is_vstreamout_global,
  input  logic [NUM_COL-1:0]              mux_control,
  input  logic [NUM_COL-1:0][DATA_W-1:0]  col_data,
  input  logic [NUM_COL-1:0]              col_valid,
  input  logic [NUM_COL-1:0]              col_done,
  output logic [NUM_COL-1:0]              col_stall,
  output logic [DATA_W-1:0]               m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [31:0]                     beat_count,
  output logic                            sel_err
);

  state_e            state_q, state_d;
  logic [31:0]       beat_count_q, beat_count_d;
  logic              sel_err_q, sel_err_d;

  logic              in_stream;
  logic              multi_hot;
  logic              onehot;
  logic              sel_hit;
  logic              sel_done;
  logic              push_last;
  logic              bad_valid;
  logic              pop;
  logic              space;
  logic              accept;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W:0]   fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign in_stream = (state_q == STREAM);
  assign multi_hot = |(mux_control & (mux_control - NUM_COL'(1)));
  assign onehot    = (mux_control != '0) && !multi_hot;
  assign sel_hit   = |(mux_control & col_valid);
  assign sel_done  = |(mux_control & col_valid & col_done);
  assign push_last = sel_done & mux_control[NUM_COL-1];
  assign bad_valid = |(col_valid & ~mux_control);

  // A full buffer still has room this cycle if the head is leaving
  assign pop    = m_axis_tvalid & m_axis_tready;
  assign space  = !fifo_full || pop;
  assign accept = in_stream && onehot && sel_hit && space;

  // Select mux: OR of the enabled columns (only ever one when a beat is taken)
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_COL; i++) begin
      if (mux_control[i]) sel_data = sel_data | col_data[i];
    end
  end

  // Only the selected column may advance, and only while there is room
  always_comb begin
    col_stall = '1;
    for (int i = 0; i < NUM_COL; i++) begin
      col_stall[i] = !(mux_control[i] && in_stream && onehot && space);
    end
  end

  // Next-state, frame beat counter and sticky selection error
  always_comb begin
    state_d      = state_q;
    beat_count_d = beat_count_q;
    sel_err_d    = sel_err_q | (in_stream & (bad_valid | multi_hot));
    case (state_q)
      IDLE: begin
        if (is_vstreamout_global) begin
          state_d      = STREAM;
          beat_count_d = '0;
        end
      end
      STREAM: begin
        if (accept) beat_count_d = sat_inc32(beat_count_q);
        if ((accept && push_last) || !is_vstreamout_global) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && !is_vstreamout_global) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_count_q <= '0;
      sel_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_count_q <= beat_count_d;
      sel_err_q    <= sel_err_d;
    end
  end

  // ---- buffer stage: {tlast, data} queued toward the egress ----
  vstreamout_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (m_axis_tready),
    .wdata_i ({push_last, sel_data}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Outputs read zero whenever nothing is queued, including right after reset
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
  assign m_axis_tlast  = fifo_empty ? 1'b0 : fifo_rdata[DATA_W];
  assign beat_count    = beat_count_q;
  assign sel_err       = sel_err_q;

endmodule

// File: tb/tb_vstreamout_collector.sv
// Directed bench for the stream-out collector: a per-cycle vector table for
// the basic stream / selection-error / early-stop behaviour, then hand-written
// sequences for async reset, a full 4-column frame, backpressure and
// multi-hot selection.
module tb_vstreamout_collector;
  import vstreamout_collector_pkg::*;

  localparam int NC = 4;
  localparam int DW = 64;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   glob;
  logic [NC-1:0]          mux, valid, done, stall;
  logic [NC-1:0][DW-1:0]  cdata;
  logic [DW-1:0]          tdata;
  logic                   tvalid, tready, tlast;
  logic [31:0]            bcount;
  logic                   serr;

  int n_checks = 0;
  int n_pass   = 0;
  int k;
  bit collect  = 1'b0;
  logic [64:0] got_q [$];

  typedef struct {
    logic        glob;
    logic [3:0]  mux, valid, done;
    logic [63:0] dat;
    logic [3:0]  e_stall;
    logic        e_tvalid;
    logic [63:0] e_tdata;
    logic        e_tlast;
    logic [31:0] e_bc;
    logic        e_err;
    state_e      e_state;
  } vec_t;

  vec_t tbl [14];

  always #5 clk = ~clk;

  vstreamout_collector dut (
    .clk                  (clk),
    .rst                  (rst),
    .is_vstreamout_global (glob),
    .mux_control          (mux),
    .col_data             (cdata),
    .col_valid            (valid),
    .col_done             (done),
    .col_stall            (stall),
    .m_axis_tdata         (tdata),
    .m_axis_tvalid        (tvalid),
    .m_axis_tready        (tready),
    .m_axis_tlast         (tlast),
    .beat_count           (bcount),
    .sel_err              (serr)
  );

  always @(negedge clk) begin
    if (collect && tvalid && tready) got_q.push_back({tlast, tdata});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic set_cdata(input logic [63:0] dat);
    for (int i = 0; i < NC; i++) cdata[i] = {4'(i), dat[59:0]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; glob = 1'b0; mux = '0; valid = '0; done = '0; tready = 1'b1;
    cdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; glob = 1'b0; mux = '0; valid = '0; done = '0; tready = 1'b1;
    cdata = '0;

    //               glob  mux   valid done  dat        stall tv    tdata      tl    bc     err   state
    tbl[0]  = '{1'b0, 4'h0, 4'h0, 4'h0, 64'h0,     4'hF, 1'b0, 64'h0,     1'b0, 32'd0, 1'b0, IDLE};
    tbl[1]  = '{1'b1, 4'h1, 4'h0, 4'h0, 64'h0,     4'hF, 1'b0, 64'h0,     1'b0, 32'd0, 1'b0, IDLE};
    tbl[2]  = '{1'b1, 4'h1, 4'h1, 4'h0, 64'hA1,    4'hE, 1'b0, 64'h0,     1'b0, 32'd0, 1'b0, STREAM};
    tbl[3]  = '{1'b1, 4'h1, 4'h1, 4'h0, 64'hA2,    4'hE, 1'b1, 64'hA1,    1'b0, 32'd1, 1'b0, STREAM};
    tbl[4]  = '{1'b1, 4'h1, 4'h1, 4'h1, 64'hA3,    4'hE, 1'b1, 64'hA2,    1'b0, 32'd2, 1'b0, STREAM};
    tbl[5]  = '{1'b1, 4'h1, 4'h0, 4'h0, 64'h0,     4'hE, 1'b1, 64'hA3,    1'b0, 32'd3, 1'b0, STREAM};
    tbl[6]  = '{1'b1, 4'h2, 4'h1, 4'h0, 64'hB1,    4'hD, 1'b0, 64'h0,     1'b0, 32'd3, 1'b0, STREAM};
    tbl[7]  = '{1'b1, 4'h2, 4'h0, 4'h0, 64'h0,     4'hD, 1'b0, 64'h0,     1'b0, 32'd3, 1'b1, STREAM};
    tbl[8]  = '{1'b1, 4'h3, 4'h3, 4'h0, 64'hC1,    4'hF, 1'b0, 64'h0,     1'b0, 32'd3, 1'b1, STREAM};
    tbl[9]  = '{1'b1, 4'h2, 4'h0, 4'h0, 64'h0,     4'hD, 1'b0, 64'h0,     1'b0, 32'd3, 1'b1, STREAM};
    tbl[10] = '{1'b0, 4'h1, 4'h1, 4'h0, 64'hA4,    4'hE, 1'b0, 64'h0,     1'b0, 32'd3, 1'b1, STREAM};
    tbl[11] = '{1'b0, 4'h1, 4'h0, 4'h0, 64'h0,     4'hF, 1'b1, 64'hA4,    1'b0, 32'd4, 1'b1, DRAIN};
    tbl[12] = '{1'b0, 4'h1, 4'h0, 4'h0, 64'h0,     4'hF, 1'b0, 64'h0,     1'b0, 32'd4, 1'b1, DRAIN};
    tbl[13] = '{1'b0, 4'h1, 4'h0, 4'h0, 64'h0,     4'hF, 1'b0, 64'h0,     1'b0, 32'd4, 1'b1, IDLE};

    // Outputs while reset is held
    @(negedge clk);
    check("rst.tvalid", 64'(tvalid), 64'd0);
    check("rst.tlast",  64'(tlast),  64'd0);
    check("rst.tdata",  tdata,       64'd0);
    check("rst.stall",  64'(stall),  64'hF);
    check("rst.bcount", 64'(bcount), 64'd0);
    check("rst.selerr", 64'(serr),   64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Table-driven per-cycle vectors
    for (int r = 0; r < 14; r++) begin
      glob = tbl[r].glob; mux = tbl[r].mux; valid = tbl[r].valid; done = tbl[r].done;
      tready = 1'b1;
      set_cdata(tbl[r].dat);
      @(negedge clk);
      check($sformatf("r%0d.stall", r),  64'(stall),       64'(tbl[r].e_stall));
      check($sformatf("r%0d.tvalid", r), 64'(tvalid),      64'(tbl[r].e_tvalid));
      check($sformatf("r%0d.bcount", r), 64'(bcount),      64'(tbl[r].e_bc));
      check($sformatf("r%0d.selerr", r), 64'(serr),        64'(tbl[r].e_err));
      check($sformatf("r%0d.state", r),  64'(dut.state_q), 64'(tbl[r].e_state));
      if (tbl[r].e_tvalid) begin
        check($sformatf("r%0d.tdata", r), tdata,      tbl[r].e_tdata);
        check($sformatf("r%0d.tlast", r), 64'(tlast), 64'(tbl[r].e_tlast));
      end
      step();
    end

    // Asynchronous reset with three beats queued
    glob = 1'b1; mux = '0; valid = '0; done = '0;
    step();
    tready = 1'b0; mux = 4'h1; valid = 4'h1;
    for (int b = 0; b < 3; b++) begin
      set_cdata(64'hD0 + 64'(b));
      step();
    end
    valid = '0;
    @(negedge clk);
    check("ar.occ_before", 64'(dut.u_fifo.count_q), 64'd3);
    check("ar.tvalid_before", 64'(tvalid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("ar.tvalid_now", 64'(tvalid), 64'd0);
    check("ar.tdata_now",  tdata,       64'd0);
    check("ar.stall_now",  64'(stall),  64'hF);
    glob = 1'b0; mux = '0; tready = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    check("ar.state",  64'(dut.state_q), 64'(IDLE));
    check("ar.bcount", 64'(bcount),      64'd0);
    check("ar.selerr", 64'(serr),        64'd0);
    step();
    @(negedge clk);
    check("ar.no_partial", 64'(tvalid), 64'd0);

    // Full frame: columns 0..3, two beats each, mux shifting on done
    do_reset();
    glob = 1'b1;
    step();
    got_q.delete();
    collect = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < 2; b++) begin
        mux   = 4'(1 << c);
        valid = 4'(1 << c);
        done  = (b == 1) ? 4'(1 << c) : 4'h0;
        set_cdata(64'(c * 16 + b));
        step();
      end
    end
    valid = '0; done = '0;
    @(negedge clk);
    check("fr.state_drain", 64'(dut.state_q), 64'(DRAIN));
    check("fr.bcount", 64'(bcount), 64'd8);
    repeat (3) step();
    @(negedge clk);
    check("fr.hold_drain", 64'(dut.state_q), 64'(DRAIN));
    check("fr.empty", 64'(tvalid), 64'd0);
    check("fr.nbeats", 64'(got_q.size()), 64'd8);
    for (int j = 0; j < 8 && j < got_q.size(); j++) begin
      check($sformatf("fr.data%0d", j), got_q[j][63:0], {4'(j / 2), 60'((j / 2) * 16 + (j % 2))});
      check($sformatf("fr.last%0d", j), 64'(got_q[j][64]), 64'(j == 7));
    end
    collect = 1'b0;
    glob = 1'b0;
    begin
      int w;
      w = 0;
      step();
      while (dut.state_q != IDLE && w < 5) begin
        step();
        w++;
      end
      check("fr.state_idle", 64'(dut.state_q), 64'(IDLE));
    end

    // Backpressure: tready low for 10 cycles, then full-occupancy streaming
    do_reset();
    glob = 1'b1;
    step();
    got_q.delete();
    collect = 1'b1;
    mux = 4'h1; valid = 4'h1; done = '0; tready = 1'b0; k = 0;
    for (int j = 0; j < 10; j++) begin
      set_cdata(64'h5000 + 64'(k));
      @(negedge clk);
      check($sformatf("bp%0d.stall", j), 64'(stall[0]), 64'(j >= 4));
      if (j >= 1) check($sformatf("bp%0d.tdata_hold", j), tdata, 64'h5000);
      if (j == 9) check("bp.occ_full", 64'(dut.u_fifo.count_q), 64'd4);
      if (j < 4) k++;
      step();
    end
    tready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      valid = (k < 10) ? 4'h1 : 4'h0;
      set_cdata(64'h5000 + 64'(k));
      @(negedge clk);
      check($sformatf("tp%0d.stall", j), 64'(stall[0]), 64'd0);
      check($sformatf("tp%0d.occ", j), 64'(dut.u_fifo.count_q), 64'd4);
      check($sformatf("tp%0d.head", j), tdata, 64'h5000 + 64'(j));
      k++;
      step();
    end
    valid = '0;
    begin
      int w;
      w = 0;
      @(negedge clk);
      while (tvalid && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("bp.drain_done", 64'(tvalid), 64'd0);
    end
    collect = 1'b0;
    check("bp.nbeats", 64'(got_q.size()), 64'd10);
    for (int j = 0; j < 10 && j < got_q.size(); j++) begin
      check($sformatf("bp.data%0d", j), got_q[j][63:0], 64'h5000 + 64'(j));
    end
    check("bp.bcount", 64'(bcount), 64'd10);

    // Multi-hot selection with valid only from a selected column
    do_reset();
    glob = 1'b1;
    step();
    mux = 4'b0110; valid = 4'b0010; set_cdata(64'hEE);
    @(negedge clk);
    check("mh.stall", 64'(stall), 64'hF);
    step();
    valid = '0;
    @(negedge clk);
    check("mh.selerr", 64'(serr),   64'd1);
    check("mh.bcount", 64'(bcount), 64'd0);
    check("mh.tvalid", 64'(tvalid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vstreamout_collector.md
VSTREAMOUT_COLLECTOR -- requirements
Module: vstreamout_collector

Interface
REQ-001 SHALL have parameter NUM_COL, default num_col (shared definition), meaning number of CGRA columns; legal range is at least 2.
REQ-002 SHALL have parameter DATA_W, default 64, meaning per-column and output data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries; SHALL be a power of 2 and at least 2.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 is_vstreamout_global  in  1  stream-out phase active, from the stream-out controller.
REQ-007 mux_control  in  NUM_COL  one-hot selection of the column allowed to supply; zero means none.
REQ-008 col_data  in  NUM_COL x DATA_W  per-column result data.
REQ-009 col_valid  in  NUM_COL  per-column data-valid.
REQ-010 col_done  in  NUM_COL  per-column last-beat marker, qualified by col_valid.
REQ-011 col_stall  out  NUM_COL  per-column hold request; 1 means the column must not advance.
REQ-012 m_axis_tdata / m_axis_tvalid / m_axis_tready / m_axis_tlast  out/out/in/out  DATA_W/1/1/1  AXI-Stream master toward the network egress.
REQ-013 beat_count  out  32  beats accepted in the current or last frame.
REQ-014 sel_err  out  1  sticky flag: valid seen from a non-selected column.

Function
REQ-015 FSM states SHALL be IDLE, STREAM and DRAIN.
REQ-016 IDLE -> STREAM SHALL occur on the first cycle is_vstreamout_global=1; beat_count SHALL clear to 0 on that transition.
REQ-017 In STREAM, a beat SHALL be accepted when (mux_control & col_valid) is non-zero and the FIFO is not full; it writes the selected col_data, plus tlast = col_done of that column AND mux_control[NUM_COL-1].
REQ-018 col_stall[i] SHALL be 0 only when mux_control[i]=1, state is STREAM and the FIFO is not full; otherwise 1. This is combinational, with 0-cycle latency from mux_control or FIFO full.
REQ-019 STREAM -> DRAIN SHALL occur on the cycle a beat with tlast=1 is accepted.
REQ-020 DRAIN -> IDLE SHALL occur when the FIFO is empty and is_vstreamout_global=0; if global stays high after the FIFO empties, the FSM SHALL remain in DRAIN.
REQ-021 The FIFO SHALL be first-in first-out. m_axis_tvalid SHALL equal not-empty. A pop SHALL occur on tvalid&tready.
REQ-022 With the FIFO full, a simultaneous push and pop SHALL be allowed only if the pop occurs that cycle; the full flag SHALL use the registered occupancy, so stall while full is held for one cycle.
REQ-023 Push and pop in the same cycle SHALL leave occupancy unchanged. Read and write pointers SHALL wrap modulo FIFO_DEPTH. Occupancy SHALL be a counter $clog2(FIFO_DEPTH)+1 bits wide.
REQ-024 m_axis_tdata/tlast SHALL be held stable while tvalid=1 and tready=0.
REQ-025 The output path SHALL have 1-cycle latency: data accepted in cycle N is visible on m_axis in cycle N+1 when the FIFO was empty.
REQ-026 beat_count SHALL increment by 1 per accepted beat and saturate at 2^32-1.
REQ-027 sel_err SHALL set when col_valid[i]=1 and mux_control[i]=0 while in STREAM; it SHALL clear only on reset. The offending data SHALL be dropped.
REQ-028 If mux_control is not one-hot (more than one bit set), no beat SHALL be accepted, all col_stall SHALL be 1, and sel_err SHALL be set.
REQ-029 If is_vstreamout_global falls in STREAM before tlast, the FSM SHALL go to DRAIN, and the final queued beat SHALL be emitted without tlast.

Reset
REQ-030 On rst: state=IDLE, FIFO empty, pointers=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, col_stall=all 1, beat_count=0, sel_err=0.
REQ-031 Reset asserted mid-frame SHALL discard FIFO contents immediately, with no partial beat emitted after deassertion.

Structure
REQ-032 NUM_COL default, state enum type and FIFO_DEPTH default SHALL live in the shared package alongside num_col.
REQ-033 The FIFO SHALL be one sub-module, vstreamout_fifo (push/pop/full/empty, parameterised DATA_W+1 by FIFO_DEPTH); the FSM, select mux and counters SHALL be in the top level.

Verification
REQ-034 NUM_COL=4, global rises, mux_control=0001, col0 sends 3 beats with done on the 3rd -> 3 beats out, tlast=0 on all, beat_count=3, state STREAM.
REQ-035 Full frame: columns 0..3 send 2 beats each, mux_control shifting on each done -> 8 beats out in column order, tlast only on beat 8, then DRAIN -> IDLE after global=0.
REQ-036 tready=0 for 10 cycles during streaming -> FIFO fills at 4, col_stall[sel]=1, no data lost or duplicated, tdata stable; after release, the order is preserved.
REQ-037 mux_control=0010 with col_valid=0001 -> sel_err=1, no beat pushed, beat_count unchanged.
REQ-038 rst pulsed asynchronously with 3 beats queued -> tvalid=0 within the same cycle, and after release the FSM is IDLE with beat_count=0.
REQ-039 Push and pop in the same cycle at occupancy 4 with tready=1 -> occupancy stays 4 and throughput is 1 beat per cycle.
